// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port: instruction fetch (A)
// and data access (B). Latches the winning request and acks the owner with read data.
//
// state | meaning
// IDLE  | port free; arbitrate pending requests
// BUSY  | request on the memory port; waiting for mem_ready or timeout
// DONE  | one-cycle ack/err to the owner; requests ignored
module mem_port_arbiter #(
  parameter bit          PRIORITY_A = 1'b0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_we,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_we,
  output logic        b_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        grant_sel,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [16:0] TO_VAL = 17'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        win_b;
  logic        grant_d, req_d, we_d, a_ack_d, b_ack_d, err_d;
  logic [31:0] addr_d, wdata_d, rdata_d;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_sel <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_sel <= grant_d;
      mem_req   <= req_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      err       <= err_d;
      rdata     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_sel;
    req_d   = mem_req;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    we_d    = mem_we;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata;
    // On contention round-robin hands the port to whoever did not own it last
    if (a_req && b_req) win_b = PRIORITY_A ? 1'b0 : ~grant_sel;
    else                win_b = b_req;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_d = win_b;
          addr_d  = win_b ? b_addr  : a_addr;
          wdata_d = win_b ? b_wdata : a_wdata;
          we_d    = win_b ? b_we    : a_we;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc[16] ? cnt_q : cnt_inc[15:0];
        if (mem_ready) begin
          rdata_d = mem_rdata;
          a_ack_d = ~grant_sel;
          b_ack_d = grant_sel;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (TO_EN && (cnt_inc == TO_VAL)) begin
          rdata_d = '0;
          a_ack_d = ~grant_sel;
          b_ack_d = grant_sel;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
